link_rr_arbiter: RTL and testbench
==================================

Name: link_rr_arbiter

Overview:
- Shares one WIDTH-bit point-to-point link between NUM_REQ parameterised sources and a single sink.
- Round-robin arbitration with packet locking: a source keeps the link until its last beat has transferred.
- One registered output stage, so link timing is isolated from requester logic.
- Sits between source instances and one sink; all instances are built with the same WIDTH.

Parameters:
- WIDTH, 16, data width of every requester and of the output link.
- NUM_REQ, 4, number of requesters; legal range is 2 to 16.
- IDX_W, $clog2(NUM_REQ), derived localparam giving the width of requester index fields; must not be overridden.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*WIDTH  packed beats; requester i uses bits [i*WIDTH +: WIDTH].
- req_last  input  NUM_REQ  per-requester end-of-packet flag.
- req_ready  output  NUM_REQ  per-requester beat accepted; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  beat data.
- out_last  output  1  end-of-packet flag travelling with the beat.
- out_src  output  IDX_W  index of the requester that produced the beat.
- out_ready  input  1  sink accepts the beat.
- busy  output  1  high when the FSM is LOCKED or out_valid is high.

Behaviour:
- Reset: every register is set on a clk edge while rst_n=0.
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - state=IDLE, lock_idx=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-packet discards the held beat and the lock; no beat is replayed.
- can_accept = !out_valid | out_ready.
  - This allows one beat per cycle with back-to-back throughput.
- Upstream accept: a beat from requester i transfers when req_valid[i] & req_ready[i] in the same cycle.
  - The beat appears on the output one cycle after acceptance (latency 1).
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - winner = first i with req_valid[i]=1, searching (rr_ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[winner] = can_accept; every other req_ready bit is 0.
  - This gives a combinational req_valid to req_ready path. It is intentional and must be documented at integration.
  - On accept with req_last=0: go to LOCKED and set lock_idx=winner.
  - On accept with req_last=1: stay in IDLE (single-beat packet).
  - On any accept: set rr_ptr=winner.
- LOCKED:
  - req_ready[lock_idx] = can_accept; all other bits are 0, even if other requesters are valid.
  - If the locked requester deasserts valid mid-packet, the link idles and the lock is held; there is no timeout.
  - On accept with req_last=1: go to IDLE. rr_ptr already equals lock_idx.
- Output register:
  - Loads {data, last, src} on accept.
  - When out_valid & out_ready & no new accept: clear out_valid. Data fields hold their last value.
  - When out_valid & !out_ready: all output fields must stay stable.
- Fairness: a continuously valid requester is granted within NUM_REQ-1 packets of other requesters.
- Simultaneous events:
  - Sink drain and new accept in the same cycle: out_valid stays 1 and the new beat replaces the drained one.
  - New requests arriving while a requester is locked do not change the lock.
- rr_ptr wraps modulo NUM_REQ; NUM_REQ need not be a power of two.
- Assertions:
  - req_ready is onehot0.
  - Output fields are stable under backpressure.
  - out_src equals lock_idx for non-first beats.

Decomposition:
- Package link_arb_pkg holds:
  - typedef arb_state_e {IDLE, LOCKED}.
  - function rr_pick(valid, ptr) returning {found, idx}, reusable by other schedulers.
- Sub-module link_rr_pick is the combinational round-robin priority picker, parameterised by NUM_REQ.
  - The FSM, pointer and output register stay in link_rr_arbiter.

Test Plan:
- Reset, then req_valid=4'b1111, all req_last=1, out_ready=1 → grants 0,1,2,3,0 on consecutive cycles; out_src follows one cycle later.
- Requester 2 sends a 3-beat packet (0xA001,0xA002,0xA003 last) while requester 0 stays valid → out shows all three with out_src=2 contiguously, then requester 0's beat.
- out_ready=0 for 5 cycles with out_valid=1, data 0x1234 → out_data holds 0x1234, req_ready=0 throughout; transfer resumes on the first cycle out_ready=1.
- Locked requester 1 drops valid for 3 cycles mid-packet while requester 3 is valid → req_ready[3] stays 0, out_valid falls after drain, packet completes, then requester 3 is granted.
- rst_n=0 for one cycle mid-packet with out_valid=1 → next cycle out_valid=0, state IDLE, requester 0 has first priority.
- NUM_REQ=3 and WIDTH=8 build with all requesters valid → grant order wraps 0,1,2,0 and req_ready is never multi-hot.

Source files
------------

// File: rtl/link_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | link_arb_pkg - shared types and round-robin pick helper for link arbiter |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package link_arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of valid[n-1:0], searching upward from ptr+1 with wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int unsigned          n);
    pick_t                res;
    logic [MAX_IDX_W-1:0] pos;
    res = '0;
    for (int unsigned off = 1; off <= MAX_REQ; off++) begin
      pos = MAX_IDX_W'((32'(ptr) + off) % n);
      if (off <= n && !res.found && valid[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/link_rr_pick.sv
// +--------------------------------------------------------------------------+
// | link_rr_pick - combinational round-robin priority picker                 |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module link_rr_pick
  import link_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_REQ-1:0]   valid_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;
  pick_t                pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
    ptr_ext                = '0;
    ptr_ext[IDX_W-1:0]     = ptr;
    pick                   = rr_pick(valid_ext, ptr_ext, NUM_REQ);
  end

  assign found = pick.found;
  assign idx   = pick.idx[IDX_W-1:0];

  generate
    if (IDX_W < MAX_IDX_W) begin : g_idx_pad
      logic pad_unused;
      assign pad_unused = |pick.idx[MAX_IDX_W-1:IDX_W];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/link_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | link_rr_arbiter - packet-locking round-robin arbiter onto one link       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module link_rr_arbiter
  import link_arb_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [IDX_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic                     busy
);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] lock_idx, rr_ptr, win_idx, grant_idx;
  logic             win_found, can_accept, accept;

  link_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  assign can_accept = !out_valid || out_ready;
  assign grant_idx  = (state == LOCKED) ? lock_idx : win_idx;

  // req_ready depends combinationally on req_valid while IDLE.
  always_comb begin
    req_ready = '0;
    if (state == LOCKED || win_found) req_ready[grant_idx] = can_accept;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !req_last[grant_idx]) state_nxt = LOCKED;
      LOCKED:  if (accept &&  req_last[grant_idx]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_idx  <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr    <= grant_idx;
        lock_idx  <= grant_idx;
        out_valid <= 1'b1;
        out_data  <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_last  <= req_last[grant_idx];
        out_src   <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == LOCKED) || out_valid;

  a_ready_onehot0: assert property (@(posedge clk) !rst_n || $onehot0(req_ready));
  a_hold_stable: assert property (@(posedge clk)
    (rst_n && out_valid && !out_ready) |=> $stable({out_valid, out_data, out_last, out_src}));
  a_lock_src: assert property (@(posedge clk)
    (rst_n && state == LOCKED && accept) |=> (out_src == $past(lock_idx)));

endmodule

`default_nettype wire

// File: tb/tb_link_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_link_rr_arbiter - table, directed and random checks of the arbiter    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_link_rr_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n     = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid, out_last, busy;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_src;
  logic           out_ready = 1'b0;

  logic [N3-1:0]    req_valid_3 = '0;
  logic [N3*W3-1:0] req_data_3  = '0;
  logic [N3-1:0]    req_last_3  = '0;
  logic [N3-1:0]    req_ready_3;
  logic             out_valid_3, out_last_3, busy_3;
  logic [W3-1:0]    out_data_3;
  logic [1:0]       out_src_3;
  logic             out_ready_3 = 1'b0;

  link_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  link_rr_arbiter #(.WIDTH(W3), .NUM_REQ(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_3), .req_data(req_data_3),
    .req_last(req_last_3), .req_ready(req_ready_3), .out_valid(out_valid_3),
    .out_data(out_data_3), .out_last(out_last_3), .out_src(out_src_3),
    .out_ready(out_ready_3), .busy(busy_3)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: output register contents, owning source (-1 = none), last grant.
  bit          model_ok = 0;
  bit          m_valid;
  logic [15:0] m_data;
  bit          m_last;
  int          m_src, m_lock, m_ptr;

  logic [N-1:0]  got_ready;
  logic [N3-1:0] got_ready3;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic [N-1:0] l, input logic ordy, input logic rstn);
    int         g;
    bit         gready;
    logic [N-1:0] exp_r;
    req_valid = v; req_data = d; req_last = l; out_ready = ordy; rst_n = rstn;
    #1;
    g = -1;
    if (m_lock >= 0) g = m_lock;
    else for (int k = 1; k <= N; k++) if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    gready = (g >= 0) && (!m_valid || ordy);
    exp_r  = gready ? N'(1 << g) : '0;
    got_ready  = req_ready;
    got_ready3 = req_ready_3;
    if (rstn && model_ok) begin
      check("req_ready", 32'(req_ready), 32'(exp_r));
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    end
    @(posedge clk);
    if (!rstn) begin
      model_ok = 1; m_valid = 0; m_data = '0; m_last = 0; m_src = 0;
      m_lock = -1; m_ptr = N - 1;
    end else if (gready && v[g]) begin
      m_valid = 1; m_data = d[g*W +: W]; m_last = l[g]; m_src = g;
      m_ptr = g; m_lock = l[g] ? -1 : g;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    if (model_ok) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_last", 32'(out_last), 32'(m_last));
      check("out_src", 32'(out_src), 32'(m_src));
      check("busy", 32'(busy), 32'((m_lock >= 0) || m_valid));
    end
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         ordy;
    logic [N-1:0] exp_ready;
    logic         exp_ov;
    logic [W-1:0] exp_data;
    logic [IW-1:0] exp_src;
  } vec_t;

  vec_t           tbl [6];
  logic [N*W-1:0] dfix;
  logic [N3-1:0]  exp3 [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 16'hD000, 2'd0};
    tbl[1] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 16'hD001, 2'd1};
    tbl[2] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 16'hD002, 2'd2};
    tbl[3] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3};
    tbl[4] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 16'hD000, 2'd0};
    tbl[5] = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 16'hD000, 2'd0};
    dfix   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

    @(negedge clk);
    drive('0, '0, '0, 1'b1, 1'b0);
    drive('0, '0, '0, 1'b1, 1'b0);

    // Round-robin rotation with single-beat packets
    foreach (tbl[i]) begin
      drive(tbl[i].v, dfix, tbl[i].l, tbl[i].ordy, 1'b1);
      check("tbl_ready", 32'(got_ready), 32'(tbl[i].exp_ready));
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
      check("tbl_out_data", 32'(out_data), 32'(tbl[i].exp_data));
      check("tbl_out_src", 32'(out_src), 32'(tbl[i].exp_src));
    end

    // Requester 2 three-beat packet holds the link against requester 0
    drive('0, '0, '0, 1'b1, 1'b0);
    drive(4'b0100, {16'h0, 16'hA001, 16'h0, 16'h0B00}, 4'b0000, 1'b1, 1'b1);
    check("pkt_b1", 32'({out_src, out_data}), 32'({2'd2, 16'hA001}));
    drive(4'b0101, {16'h0, 16'hA002, 16'h0, 16'h0B00}, 4'b0001, 1'b1, 1'b1);
    check("pkt_b2", 32'({out_src, out_data}), 32'({2'd2, 16'hA002}));
    drive(4'b0101, {16'h0, 16'hA003, 16'h0, 16'h0B00}, 4'b0101, 1'b1, 1'b1);
    check("pkt_b3", 32'({out_src, out_data, out_last}), 32'({2'd2, 16'hA003, 1'b1}));
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'h0B00}, 4'b0001, 1'b1, 1'b1);
    check("pkt_next", 32'({out_src, out_data}), 32'({2'd0, 16'h0B00}));

    // Backpressure: beat held, nothing accepted
    drive('0, '0, '0, 1'b1, 1'b0);
    drive(4'b0001, 64'h1234, 4'b0001, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 64'h5555, 4'b0001, 1'b0, 1'b1);
      check("bp_ready", 32'(got_ready), 32'd0);
      check("bp_hold", 32'({out_valid, out_data}), 32'({1'b1, 16'h1234}));
    end
    drive(4'b0001, 64'h5555, 4'b0001, 1'b1, 1'b1);
    check("bp_resume", 32'({got_ready, out_data}), 32'({4'b0001, 16'h5555}));

    // Locked requester 1 stalls; requester 3 must wait
    drive('0, '0, '0, 1'b1, 1'b0);
    drive(4'b0010, {48'h0, 16'h1100}, 4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1000, {16'h3300, 48'h0}, 4'b1000, 1'b1, 1'b1);
      check("stall_r3_blocked", 32'(got_ready[3]), 32'd0);
    end
    check("stall_drained", 32'(out_valid), 32'd0);
    drive(4'b1010, {16'h3300, 16'h0, 16'h1101, 16'h0}, 4'b1010, 1'b1, 1'b1);
    check("stall_finish", 32'({got_ready, out_src}), 32'({4'b0010, 2'd1}));
    drive(4'b1000, {16'h3300, 48'h0}, 4'b1000, 1'b1, 1'b1);
    check("stall_r3_grant", 32'({got_ready, out_src}), 32'({4'b1000, 2'd3}));

    // Reset mid-packet
    drive(4'b0010, {48'h0, 16'h7777}, 4'b0000, 1'b1, 1'b1);
    drive(4'b0010, {48'h0, 16'h7778}, 4'b0000, 1'b0, 1'b0);
    check("rst_mid", 32'({out_valid, busy}), 32'd0);
    drive(4'hF, dfix, 4'hF, 1'b1, 1'b1);
    check("rst_prio", 32'(got_ready), 32'b0001);

    // Three-requester build wraps 0,1,2,0
    drive('0, '0, '0, 1'b1, 1'b0);
    exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b001;
    req_valid_3 = 3'b111; req_last_3 = 3'b111; out_ready_3 = 1'b1;
    req_data_3  = {8'hC2, 8'hC1, 8'hC0};
    for (int k = 0; k < 4; k++) begin
      drive('0, '0, '0, 1'b1, 1'b1);
      check("n3_ready", 32'(got_ready3), 32'(exp3[k]));
      check("n3_src", 32'(out_src_3), 32'(k % 3));
      check("n3_data", 32'(out_data_3), 32'(8'hC0 + 8'(k % 3)));
    end
    req_valid_3 = '0;

    // Random traffic against the model
    drive('0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 400; k++) begin
      drive(N'($urandom), {$urandom, $urandom}, N'($urandom & $urandom),
            ($urandom % 4) != 0, ($urandom % 60) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
